// File: rtl/seq_mult_16x16.sv
// Iterative 16x16 unsigned shift-add multiplier with valid/ready handshakes,
// plus the 32-bit carry-lookahead adder it drives every cycle.

module CLA_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);
   logic [31:0] g_s;
   logic [31:0] p_s;
   logic [31:0] c_s;
   logic [7:0]  grp_g_s;
   logic [7:0]  grp_p_s;
   logic [8:0]  grp_c_s;

   assign g_s        = a & b;
   assign p_s        = a ^ b;
   assign grp_c_s[0] = cin;

   // Eight 4-bit lookahead groups; group carries chain through grp_g/grp_p.
   for (genvar k = 0; k < 8; k++) begin : g_grp
      localparam int B = 4 * k;

      assign grp_p_s[k] = p_s[B+3] & p_s[B+2] & p_s[B+1] & p_s[B];
      assign grp_g_s[k] = g_s[B+3]
                        | (p_s[B+3] & g_s[B+2])
                        | (p_s[B+3] & p_s[B+2] & g_s[B+1])
                        | (p_s[B+3] & p_s[B+2] & p_s[B+1] & g_s[B]);

      assign c_s[B]   = grp_c_s[k];
      assign c_s[B+1] = g_s[B] | (p_s[B] & grp_c_s[k]);
      assign c_s[B+2] = g_s[B+1]
                      | (p_s[B+1] & g_s[B])
                      | (p_s[B+1] & p_s[B] & grp_c_s[k]);
      assign c_s[B+3] = g_s[B+2]
                      | (p_s[B+2] & g_s[B+1])
                      | (p_s[B+2] & p_s[B+1] & g_s[B])
                      | (p_s[B+2] & p_s[B+1] & p_s[B] & grp_c_s[k]);

      assign grp_c_s[k+1] = grp_g_s[k] | (grp_p_s[k] & grp_c_s[k]);
   end

   assign sum  = p_s ^ c_s;
   assign cout = grp_c_s[8];
endmodule

module seq_mult_16x16 #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);
   // The adder datapath is fixed at 32 bits, so no other operand width can work.
   if (WIDTH != 16) begin : g_width_check
      $error("seq_mult_16x16: WIDTH must be 16");
   end

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]        state_r;
   logic [31:0]       mcand_r;
   logic [WIDTH-1:0]  mplier_r;
   logic [31:0]       acc_r;
   logic [4:0]        count_r;
   logic [31:0]       product_r;
   logic [31:0]       sum_s;
   logic              cout_unused_s;
   logic [31:0]       acc_next_s;

   // cout is always 0: a 16x16 product never exceeds 32 bits.
   CLA_32bit u_cla (
      .a    (acc_r),
      .b    (mcand_r),
      .cin  (1'b0),
      .sum  (sum_s),
      .cout (cout_unused_s)
   );

   // Accumulator value for the current step: add only when the multiplier LSB is set.
   always_comb begin
      acc_next_s = acc_r;
      if (mplier_r[0]) begin
         acc_next_s = sum_s;
      end else begin
         acc_next_s = acc_r;
      end
   end

   // Control FSM and shift-add datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         mcand_r   <= 32'd0;
         mplier_r  <= '0;
         acc_r     <= 32'd0;
         count_r   <= 5'd0;
         product_r <= 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  mcand_r  <= {{(32-WIDTH){1'b0}}, a};
                  mplier_r <= b;
                  acc_r    <= 32'd0;
                  count_r  <= 5'd0;
                  state_r  <= ST_RUN;
               end
            end
            ST_RUN: begin
               acc_r    <= acc_next_s;
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               if (count_r != 5'd16) begin
                  count_r <= count_r + 5'd1;
               end
               // Sixteenth step: publish the sum produced by this very step.
               if (count_r == 5'd15) begin
                  product_r <= acc_next_s;
                  state_r   <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_r == ST_IDLE);
   assign out_valid = (state_r == ST_DONE);
   assign product   = product_r;
endmodule

// File: tb/tb_seq_mult_16x16.sv
// Self-checking bench for seq_mult_16x16: directed corner cases plus random
// operands, compared against plain a*b arithmetic and an 18-cycle issue schedule.

module tb_seq_mult_16x16;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] product;

   int checks = 0;
   int errors = 0;

   seq_mult_16x16 #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
      logic [31:0] xx;
      logic [31:0] yy;
      xx = {16'd0, x};
      yy = {16'd0, y};
      return xx * yy;
   endfunction

   // One full transaction; bp = number of cycles out_ready stays low after out_valid.
   task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input int bp);
      logic [31:0] expv;
      int          lat;
      logic        busy_ok;
      logic        hold_ok;
      expv = ref_mul(av, bv);
      check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      a         = av;
      b         = bv;
      in_valid  = 1'b1;
      out_ready = (bp == 0);
      step();
      // operands must have been sampled already; scramble them
      in_valid = 1'b0;
      a        = 16'($urandom);
      b        = 16'($urandom);
      lat      = 0;
      busy_ok  = 1'b1;
      while (!out_valid && lat < 40) begin
         if (in_ready) busy_ok = 1'b0;
         in_valid = 1'($urandom_range(0, 1));
         a        = 16'($urandom);
         b        = 16'($urandom);
         step();
         lat++;
      end
      in_valid = 1'b0;
      if (in_ready) busy_ok = 1'b0;
      check("latency", lat, 32'd16);
      check("in_ready_low_while_busy", {31'd0, busy_ok}, 32'd1);
      check("product", product, expv);
      hold_ok = 1'b1;
      for (int i = 0; i < bp; i++) begin
         step();
         if (out_valid !== 1'b1 || product !== expv) hold_ok = 1'b0;
      end
      if (bp > 0) check("backpressure_hold", {31'd0, hold_ok}, 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("out_valid_after_retire", {31'd0, out_valid}, 32'd0);
      check("in_ready_after_retire", {31'd0, in_ready}, 32'd1);
      check("product_kept_after_retire", product, expv);
   endtask

   initial begin
      logic [31:0] exp_q[$];
      logic [31:0] expv;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 16'd0;
      b         = 16'd0;
      #1;
      step();
      step();
      rst = 1'b0;
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_product", product, 32'd0);

      do_op(16'd3, 16'd5, 0);
      check("basic_literal", product, 32'h0000_000F);
      do_op(16'hFFFF, 16'hFFFF, 0);
      check("max_literal", product, 32'hFFFE_0001);
      do_op(16'h1234, 16'h0000, 0);
      check("zero_literal", product, 32'h0000_0000);
      do_op(16'h8000, 16'h8000, 0);
      check("walking_one_literal", product, 32'h4000_0000);
      do_op(16'h00FF, 16'h0101, 5);
      check("backpressure_literal", product, 32'h0000_FFFF);

      // Abort a run with reset on its 8th step edge.
      a        = 16'd7;
      b        = 16'd9;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (7) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_product", product, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (20) begin
         step();
         if (out_valid) check("abort_no_result", {31'd0, out_valid}, 32'd0);
      end
      do_op(16'd2, 16'd2, 0);
      check("after_abort_literal", product, 32'd4);

      for (int n = 0; n < 8; n++) begin
         do_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
      end

      // Back-to-back: fresh operands every cycle, accepts only every 18 cycles.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int j = 0; j < 18 * 6; j++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         check("b2b_in_ready", {31'd0, in_ready}, {31'd0, (j % 18) == 0});
         if ((j % 18) == 0) exp_q.push_back(ref_mul(a, b));
         step();
         check("b2b_out_valid", {31'd0, out_valid}, {31'd0, (j % 18) == 16});
         if (out_valid && exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            check("b2b_product", product, expv);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_all_retired", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_mult_16x16.md
Name: seq_mult_16x16

Overview:
- Iterative unsigned shift-add multiplier. Computes a 32-bit product over 16 cycles.
- Sits directly upstream of the team's CLA_32bit: every cycle it supplies the operand pair and captures the returned sum.
- Upstream (operand source) and downstream (product consumer) connect through valid/ready handshakes.
- Intended as the multiply unit next to the existing adder chain.

Parameters:
- WIDTH, 16, operand width. Only 16 is legal because the adder datapath is fixed at 32 bits. Elaboration must fail for any other value.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair a/b valid
- in_ready  output  1  block can accept operands
- a  input  16  multiplicand, unsigned
- b  input  16  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  32  a*b, unsigned

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, in_ready=1, out_valid=0, product=0, internal count=0.
  - Reset wins over every other event.
  - A reset in RUN or DONE aborts the operation; no result is ever presented.
- States: IDLE, RUN, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE. Both are decoded from registered state.
- IDLE:
  - On an edge with in_valid&in_ready: load mcand={16'b0,a}, mplier=b, acc=0, count=0; go to RUN.
  - a/b are sampled only at this edge. Later changes on a/b have no effect.
- RUN, each edge performs one step:
  - If mplier[0]=1: acc <= CLA_32bit(acc, mcand, cin=0).sum. Otherwise acc holds.
  - mcand <<= 1 (32-bit, logical); mplier >>= 1 (logical); count <= count+1.
  - Exactly 16 steps are always executed, with no early exit even when mplier becomes 0.
  - On the step where count==15: go to DONE and load product <= final acc value, i.e. the acc update of that same step.
- DONE:
  - Hold product and out_valid until an edge with out_ready=1, then go to IDLE.
  - product keeps its value after the handshake and changes only at the next load.
- Latency and throughput:
  - Operands are accepted at edge N; out_valid rises at edge N+16.
  - If out_ready is already high, the result retires at edge N+17, the block is in IDLE after that edge, and the next accept is possible at edge N+18.
  - Minimum issue interval is 18 cycles.
- Adder:
  - One CLA_32bit instance, cin tied to 0.
  - cout is ignored: the product fits in 32 bits, so it is provably 0.
  - Adder inputs are acc and mcand directly, with no extra pipeline register.
- in_valid asserted while not in IDLE is ignored; no operands are queued.
- out_ready asserted outside DONE has no effect.
- Counters and shifts must not wrap: count is 5 bits wide and is never incremented past 16.

Test Plan:
- Basic product: rst for 2 cycles, then a=3, b=5, in_valid=1 for 1 cycle, out_ready=1 → out_valid rises exactly 16 edges after accept with product=0x0000000F; in_ready=0 throughout RUN and DONE.
- Maximum operands: a=0xFFFF, b=0xFFFF → product=0xFFFE0001.
- Zero and walking-one operands:
  - a=0x1234, b=0 → product=0, with latency still 16.
  - a=0x8000, b=0x8000 → product=0x40000000.
- Backpressure: a=0x00FF, b=0x0101, out_ready=0 for 5 cycles after out_valid rises → out_valid and product=0x0000FFFF stay stable; a one-cycle out_ready pulse retires the result; the next cycle shows in_ready=1.
- Reset mid-run: accept a=7, b=9, assert rst at the 8th RUN edge → out_valid=0, product=0, in_ready=1 the next cycle; a following a=2, b=2 returns 4.
- Back-to-back issue: in_valid held high with a new a/b every cycle and out_ready=1 → only pairs present at IDLE edges are accepted, one every 18 cycles. Each result matches a reference model; no request is accepted during RUN or DONE.
